// File: rtl/toy_bpu_redirect_ctrl.sv
// Front-end redirect sequencer: arbitrates BE/BP2 redirects, flushes the ROB for BE
// redirects, waits for the drain (bounded by a timeout) and strobes the new PC into pcgen.
module toy_bpu_redirect_ctrl #(
    parameter int PC_WIDTH      = 32,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 be_redirect_vld,
    input  logic [PC_WIDTH-1:0]  be_redirect_pc,
    output logic                 be_redirect_rdy,
    input  logic                 bp2_redirect_vld,
    input  logic [PC_WIDTH-1:0]  bp2_redirect_pc,
    output logic                 bp2_redirect_rdy,
    output logic                 rob_flush,
    input  logic                 rob_flush_done,
    output logic                 pcgen_stall,
    output logic                 pcgen_redirect_vld,
    output logic [PC_WIDTH-1:0]  pcgen_redirect_pc,
    output logic                 pcgen_redirect_src,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    // state | meaning
    // IDLE  | no redirect in flight, pcgen free to run
    // FLUSH | one-cycle ROB flush pulse for a BE redirect
    // DRAIN | waiting for ROB flush_done (bounded by DRAIN_TIMEOUT)
    // REDIR | one-cycle PC load strobe to pcgen
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        REDIR = 2'd3
    } state_t;

    localparam int DW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    state_t                state;
    logic [PC_WIDTH-1:0]   tgt_pc;
    logic                  src;
    logic [DW-1:0]         drain_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tgt_pc      <= '0;
            src         <= 1'b0;
            drain_cnt   <= '0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            // BP2 loses whenever the sequencer is busy or BE arrives in the same cycle
            if (bp2_redirect_vld && ((state != IDLE) || be_redirect_vld))
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (be_redirect_vld) begin
                        tgt_pc <= be_redirect_pc;
                        src    <= 1'b1;
                        state  <= FLUSH;
                    end else if (bp2_redirect_vld) begin
                        tgt_pc <= bp2_redirect_pc;
                        src    <= 1'b0;
                        state  <= REDIR;
                    end
                end
                FLUSH: begin
                    drain_cnt <= '0;
                    if (be_redirect_vld) begin
                        tgt_pc <= be_redirect_pc;
                        src    <= 1'b1;
                        state  <= FLUSH;
                    end else begin
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (be_redirect_vld) begin
                        tgt_pc <= be_redirect_pc;
                        src    <= 1'b1;
                        state  <= FLUSH;
                    end else if (rob_flush_done) begin
                        state  <= REDIR;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= REDIR;
                    end
                end
                REDIR: begin
                    // strobe this cycle still carries the old target; a new BE restarts afterwards
                    if (be_redirect_vld) begin
                        tgt_pc <= be_redirect_pc;
                        src    <= 1'b1;
                        state  <= FLUSH;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign be_redirect_rdy    = 1'b1;
    assign bp2_redirect_rdy   = 1'b1;
    assign rob_flush          = (state == FLUSH);
    assign pcgen_stall        = (state != IDLE);
    assign pcgen_redirect_vld = (state == REDIR);
    assign pcgen_redirect_pc  = tgt_pc;
    assign pcgen_redirect_src = src;

endmodule

// File: tb/tb_toy_bpu_redirect_ctrl.sv
// Scoreboard bench for toy_bpu_redirect_ctrl: stimulus pushes expected redirect strobes,
// a negedge monitor pops and compares them; other outputs are checked at fixed cycles.
module tb_toy_bpu_redirect_ctrl;
    localparam int PW = 32;
    localparam int DT = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          be_redirect_vld = 1'b0;
    logic [PW-1:0] be_redirect_pc = '0;
    logic          be_redirect_rdy;
    logic          bp2_redirect_vld = 1'b0;
    logic [PW-1:0] bp2_redirect_pc = '0;
    logic          bp2_redirect_rdy;
    logic          rob_flush;
    logic          rob_flush_done = 1'b0;
    logic          pcgen_stall;
    logic          pcgen_redirect_vld;
    logic [PW-1:0] pcgen_redirect_pc;
    logic          pcgen_redirect_src;
    logic          timeout_err;
    logic [CW-1:0] drop_cnt;

    toy_bpu_redirect_ctrl #(.PC_WIDTH(PW), .DRAIN_TIMEOUT(DT), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .be_redirect_vld    (be_redirect_vld),
        .be_redirect_pc     (be_redirect_pc),
        .be_redirect_rdy    (be_redirect_rdy),
        .bp2_redirect_vld   (bp2_redirect_vld),
        .bp2_redirect_pc    (bp2_redirect_pc),
        .bp2_redirect_rdy   (bp2_redirect_rdy),
        .rob_flush          (rob_flush),
        .rob_flush_done     (rob_flush_done),
        .pcgen_stall        (pcgen_stall),
        .pcgen_redirect_vld (pcgen_redirect_vld),
        .pcgen_redirect_pc  (pcgen_redirect_pc),
        .pcgen_redirect_src (pcgen_redirect_src),
        .timeout_err        (timeout_err),
        .drop_cnt           (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] pc;
        logic          src;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   flush_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [PW-1:0] pc, input logic s, input int c);
        exp_t e;
        e.pc  = pc;
        e.src = s;
        e.cyc = c;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rob_flush === 1'b1) flush_seen++;
        if (pcgen_redirect_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_redirect: got pc 0x%0h at cycle %0d, expected no strobe",
                         pcgen_redirect_pc, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("redir_pc", pcgen_redirect_pc, mon_e.pc);
                chk("redir_src", pcgen_redirect_src, mon_e.src);
                chk("redir_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int t;
        int f0;

        repeat (3) step();
        neg();
        chk("rst_be_rdy", be_redirect_rdy, 1);
        chk("rst_bp2_rdy", bp2_redirect_rdy, 1);
        chk("rst_flush", rob_flush, 0);
        chk("rst_stall", pcgen_stall, 0);
        chk("rst_redir_vld", pcgen_redirect_vld, 0);
        chk("rst_redir_pc", pcgen_redirect_pc, 0);
        chk("rst_redir_src", pcgen_redirect_src, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_drop", drop_cnt, 0);
        step();
        rst = 1'b0;

        // BE redirect, done already high
        rob_flush_done = 1'b1;
        step(); t = cyc;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h8000_0040;
        push(32'h8000_0040, 1'b1, t + 3);
        neg(); chk("t1_stall_t0", pcgen_stall, 0);
        step(); be_redirect_vld = 1'b0;
        neg(); chk("t1_flush_t1", rob_flush, 1); chk("t1_stall_t1", pcgen_stall, 1);
        step(); neg(); chk("t1_flush_t2", rob_flush, 0); chk("t1_stall_t2", pcgen_stall, 1);
        step(); neg(); chk("t1_stall_t3", pcgen_stall, 1);
        step(); neg(); chk("t1_stall_t4", pcgen_stall, 0);

        // BP2 redirect straight to pcgen
        step(); t = cyc; f0 = flush_seen;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_1000;
        push(32'h0000_1000, 1'b0, t + 1);
        step(); bp2_redirect_vld = 1'b0;
        neg(); chk("t2_flush_t1", rob_flush, 0); chk("t2_stall_t1", pcgen_stall, 1);
        step(); neg(); chk("t2_stall_t2", pcgen_stall, 0);
        chk("t2_no_flush", flush_seen - f0, 0);

        // BE and BP2 together in IDLE: BE wins
        step(); t = cyc;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_2000;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_3000;
        push(32'h0000_2000, 1'b1, t + 3);
        step(); be_redirect_vld = 1'b0; bp2_redirect_vld = 1'b0;
        neg(); chk("t2_drop_one", drop_cnt, 1); chk("t2_be_flush", rob_flush, 1);
        repeat (3) step();
        neg(); chk("t2_idle_after", pcgen_stall, 0);

        // DRAIN timeout with done held low
        rob_flush_done = 1'b0;
        step(); t = cyc;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_4440;
        push(32'h0000_4440, 1'b1, t + 6);
        step(); be_redirect_vld = 1'b0;
        repeat (4) step();
        neg(); chk("t3_timeout_not_yet", timeout_err, 0); chk("t3_stall_drain", pcgen_stall, 1);
        step(); neg(); chk("t3_timeout_set", timeout_err, 1);
        step(); neg(); chk("t3_idle_after", pcgen_stall, 0);

        // second BE in the second DRAIN cycle preempts the first
        step(); t = cyc; f0 = flush_seen;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_A000;
        step(); be_redirect_vld = 1'b0;
        step();
        step(); be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_B000;
        push(32'h0000_B000, 1'b1, t + 6);
        step(); be_redirect_vld = 1'b0; rob_flush_done = 1'b1;
        step(); step(); step();
        neg(); chk("t4_two_flushes", flush_seen - f0, 2); chk("t4_idle_after", pcgen_stall, 0);
        chk("t4_timeout_sticky", timeout_err, 1);

        // BE during REDIR: old strobe fires, new sequence follows
        step(); t = cyc;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_5000;
        push(32'h0000_5000, 1'b0, t + 1);
        step(); bp2_redirect_vld = 1'b0;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_6000;
        push(32'h0000_6000, 1'b1, t + 4);
        step(); be_redirect_vld = 1'b0;
        neg(); chk("tr_flush_after_redir", rob_flush, 1);
        repeat (3) step();
        neg(); chk("tr_idle_after", pcgen_stall, 0);

        // BP2 every cycle of a 5-cycle BE sequence
        rst = 1'b1; step(); rst = 1'b0;
        neg(); chk("t5_rst_clears_timeout", timeout_err, 0);
        rob_flush_done = 1'b0;
        step(); t = cyc;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_7000;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_9999;
        push(32'h0000_7000, 1'b1, t + 4);
        step(); be_redirect_vld = 1'b0;
        step();
        step(); rob_flush_done = 1'b1;
        step();
        step(); bp2_redirect_vld = 1'b0;
        neg(); chk("t5_drop_five", drop_cnt, 5); chk("t5_idle_after", pcgen_stall, 0);

        // 256 drops wrap the counter
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (i == 255) begin
                neg(); chk("t5_drop_255", drop_cnt, 255);
            end
            be_redirect_vld  = 1'b1;
            be_redirect_pc   = 32'hC000_0000 + 32'(i);
            bp2_redirect_vld = 1'b1;
            t = cyc;
        end
        push(32'hC000_00FF, 1'b1, t + 3);
        step(); be_redirect_vld = 1'b0; bp2_redirect_vld = 1'b0;
        neg(); chk("t5_drop_wrap", drop_cnt, 0); chk("t5_wrap_flush", rob_flush, 1);
        repeat (3) step();
        neg(); chk("t5_wrap_idle", pcgen_stall, 0);

        // reset in the middle of DRAIN
        rob_flush_done = 1'b0;
        step(); t = cyc;
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_D000;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_0001;
        push(32'h0000_D000, 1'b1, t + 6);
        step(); be_redirect_vld = 1'b0; bp2_redirect_vld = 1'b0;
        repeat (6) step();
        neg(); chk("t6_pre_timeout", timeout_err, 1); chk("t6_pre_drop", drop_cnt, 1);
        step();
        be_redirect_vld = 1'b1; be_redirect_pc = 32'h0000_E000;
        step(); be_redirect_vld = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0; f0 = flush_seen;
        neg();
        chk("t6_stall", pcgen_stall, 0);
        chk("t6_flush", rob_flush, 0);
        chk("t6_timeout", timeout_err, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_redir_vld", pcgen_redirect_vld, 0);
        step(); t = cyc;
        bp2_redirect_vld = 1'b1; bp2_redirect_pc = 32'h0000_F000;
        push(32'h0000_F000, 1'b0, t + 1);
        step(); bp2_redirect_vld = 1'b0;
        neg(); chk("t6_bp2_stall", pcgen_stall, 1);
        step(); step();
        neg(); chk("t6_idle_after", pcgen_stall, 0);
        chk("t6_no_reflush", flush_seen - f0, 0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
